blake2_g_sched: RTL and testbench

- Sequencer that time-shares one external combinational G function unit across a full BLAKE2b compression.
- Holds the 16-word working vector v and the 16-word message block m.
- Issues one G call per cycle: 8 calls per round, ROUNDS rounds. Drives G operands by schedule and writes G results back into v.
- Sits between the compression/finalisation logic, which loads v and m and reads back v, and the shared G datapath.

---
 rtl/blake2_pkg.sv | 40 ++++
 rtl/blake2_sigma_rom.sv | 21 ++
 rtl/blake2_g_sched.sv | 162 ++++++++++++++++
 tb/tb_blake2_g_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared constants for the BLAKE2b G-function sequencer: FSM encoding,
// the message permutation table and the column/diagonal word index table.
package blake2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_WORDS = 16;
    localparam int WORD_W    = 64;

    // SIGMA[row][k]: message word index; element 0 sits in the leftmost nibble.
    localparam logic [0:9][0:15][3:0] SIGMA = {
        64'h0123_4567_89AB_CDEF,
        64'hEA48_9FD6_1C02_B753,
        64'hB8C0_52FD_AE36_7194,
        64'h7931_DCBE_265A_40F8,
        64'h9057_24AF_E1BC_683D,
        64'h2C6A_0B83_4D75_FE19,
        64'hC51F_ED4A_0763_928B,
        64'hDB7E_C139_50F4_862A,
        64'h6FE9_B308_C2D7_14A5,
        64'hA284_7615_FB9E_3CD0
    };

    // G_IDX[g] = {ia, ib, ic, id}: four columns, then four diagonals.
    localparam logic [0:7][0:3][3:0] G_IDX = {
        16'h048C,
        16'h159D,
        16'h26AE,
        16'h37BF,
        16'h05AF,
        16'h16BC,
        16'h278D,
        16'h349E
    };

endpackage

// File: rtl/blake2_sigma_rom.sv
// Message-word index lookup: reduces the round number mod 10 and picks the
// two SIGMA entries used by G call g_idx of that round.
module blake2_sigma_rom
    import blake2_pkg::*;
(
    input  logic [3:0] round,
    input  logic [2:0] g_idx,
    output logic [3:0] m_idx0,
    output logic [3:0] m_idx1
);

    logic [3:0] row;

    // Rounds never exceed 15, so one conditional subtract gives round mod 10.
    always_comb begin
        row    = (round >= 4'd10) ? (round - 4'd10) : round;
        m_idx0 = SIGMA[row][{g_idx, 1'b0}];
        m_idx1 = SIGMA[row][{g_idx, 1'b1}];
    end

endmodule

// File: rtl/blake2_g_sched.sv
// BLAKE2b compression sequencer: holds v and m, issues one G call per cycle
// to an external combinational G unit and writes its results back into v.
module blake2_g_sched
    import blake2_pkg::*;
#(
    parameter int ROUNDS = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1023:0] v_in,
    input  logic [1023:0] m_in,
    output logic          ready,
    output logic          done,
    output logic [1023:0] v_out,
    output logic [63:0]   g_a,
    output logic [63:0]   g_b,
    output logic [63:0]   g_c,
    output logic [63:0]   g_d,
    output logic [63:0]   g_m0,
    output logic [63:0]   g_m1,
    input  logic [63:0]   g_a_prim,
    input  logic [63:0]   g_b_prim,
    input  logic [63:0]   g_c_prim,
    input  logic [63:0]   g_d_prim
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t     state_reg, state_next;
    logic [3:0] round_reg, round_next;
    logic [2:0] g_idx_reg, g_idx_next;
    logic       load;
    logic       run;

    logic [NUM_WORDS-1:0][WORD_W-1:0] v_words;
    logic [NUM_WORDS-1:0][WORD_W-1:0] m_words;

    logic [3:0] ia, ib, ic, id;
    logic [3:0] m_idx0, m_idx1;

    assign run = (state_reg == RUN);
    assign {ia, ib, ic, id} = G_IDX[g_idx_reg];

    blake2_sigma_rom u_sigma_rom (
        .round  (round_reg),
        .g_idx  (g_idx_reg),
        .m_idx0 (m_idx0),
        .m_idx1 (m_idx1)
    );

    // Operands always follow the current counters, whatever the state.
    always_comb begin
        g_a  = v_words[ia];
        g_b  = v_words[ib];
        g_c  = v_words[ic];
        g_d  = v_words[id];
        g_m0 = m_words[m_idx0];
        g_m1 = m_words[m_idx1];
    end

    assign v_out = v_words;

    // Next-state, counter and handshake logic.
    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        g_idx_next = g_idx_reg;
        load       = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    round_next = 4'd0;
                    g_idx_next = 3'd0;
                    state_next = RUN;
                end
            end
            RUN: begin
                g_idx_next = g_idx_reg + 3'd1;
                if (g_idx_reg == 3'd7) begin
                    round_next = round_reg + 4'd1;
                    if (round_reg == LAST_ROUND) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            round_reg <= 4'd0;
            g_idx_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            g_idx_reg <= g_idx_next;
        end
    end

    // One register per word; the four G targets are distinct, so at most one
    // of the write-back selects matches any given word.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] v_word_reg, v_word_next;
            logic [WORD_W-1:0] m_word_reg;

            // Load from v_in on start, otherwise take the G result aimed here.
            always_comb begin
                v_word_next = v_word_reg;
                if (load) begin
                    v_word_next = v_in[WORD_W*gi +: WORD_W];
                end else if (run) begin
                    if (ia == 4'(gi)) begin
                        v_word_next = g_a_prim;
                    end else if (ib == 4'(gi)) begin
                        v_word_next = g_b_prim;
                    end else if (ic == 4'(gi)) begin
                        v_word_next = g_c_prim;
                    end else if (id == 4'(gi)) begin
                        v_word_next = g_d_prim;
                    end
                end
            end

            // Working vector word storage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_word_reg <= '0;
                end else begin
                    v_word_reg <= v_word_next;
                end
            end

            // Message word storage; only written when a start is accepted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_word_reg <= '0;
                end else if (load) begin
                    m_word_reg <= m_in[WORD_W*gi +: WORD_W];
                end
            end

            assign v_words[gi] = v_word_reg;
            assign m_words[gi] = m_word_reg;
        end
    endgenerate

endmodule

// File: tb/tb_blake2_g_sched.sv
// Directed bench for blake2_g_sched: probes the G schedule, checks latency,
// the BLAKE2b("abc") digest, busy-start rejection, mid-run reset and ROUNDS=1.
module tb_blake2_g_sched;

    localparam logic [0:7][63:0] IV = {
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
        64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
        64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
    };

    logic          clk;
    logic          reset;
    logic          start0, start1;
    logic [1023:0] v_in0, m_in0, v_in1, m_in1;
    logic          ready0, done0, ready1, done1;
    logic [1023:0] v_out0, v_out1;
    logic [63:0]   ga0, gb0, gc0, gd0, gm00, gm10, gap0, gbp0, gcp0, gdp0;
    logic [63:0]   ga1, gb1, gc1, gd1, gm01, gm11, gap1, gbp1, gcp1, gdp1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int          n;
        bit          chk_op;
        logic [63:0] a, b, c, d, m0, m1;
    } probe_t;

    localparam int NPROBE = 9;
    probe_t tbl [NPROBE];

    function automatic logic [63:0] rotr(input logic [63:0] x, input int s);
        return (x >> s) | (x << (64 - s));
    endfunction

    function automatic logic [255:0] g_fn(input logic [63:0] a_i, b_i, c_i, d_i, x, y);
        logic [63:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b + x; d = rotr(d ^ a, 32); c = c + d; b = rotr(b ^ c, 24);
        a = a + b + y; d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 63);
        return {a, b, c, d};
    endfunction

    assign {gap0, gbp0, gcp0, gdp0} = g_fn(ga0, gb0, gc0, gd0, gm00, gm10);
    assign {gap1, gbp1, gcp1, gdp1} = g_fn(ga1, gb1, gc1, gd1, gm01, gm11);

    blake2_g_sched #(.ROUNDS(12)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .v_in(v_in0), .m_in(m_in0),
        .ready(ready0), .done(done0), .v_out(v_out0),
        .g_a(ga0), .g_b(gb0), .g_c(gc0), .g_d(gd0), .g_m0(gm00), .g_m1(gm10),
        .g_a_prim(gap0), .g_b_prim(gbp0), .g_c_prim(gcp0), .g_d_prim(gdp0)
    );

    blake2_g_sched #(.ROUNDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .v_in(v_in1), .m_in(m_in1),
        .ready(ready1), .done(done1), .v_out(v_out1),
        .g_a(ga1), .g_b(gb1), .g_c(gc1), .g_d(gd1), .g_m0(gm01), .g_m1(gm11),
        .g_a_prim(gap1), .g_b_prim(gbp1), .g_c_prim(gcp1), .g_d_prim(gdp1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_w(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Start dut0, optionally probe the schedule table and poke start while busy.
    task automatic run_dut0(input string tag, input logic [1023:0] vin, input logic [1023:0] min,
                            input bit probe, input bit busy, output logic [1023:0] vfinal);
        int done_at, done_cnt, ready_at;
        done_at = -1; done_cnt = 0; ready_at = -1; vfinal = '0;
        @(negedge clk);
        v_in0 = vin; m_in0 = min; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk_i({tag, "_ready_drop"}, int'(ready0), 0);
        for (int n = 0; n <= 110; n++) begin
            if (probe) begin
                for (int k = 0; k < NPROBE; k++) begin
                    if (tbl[k].n == n) begin
                        if (tbl[k].chk_op) begin
                            chk_w($sformatf("probe%0d_g_a", n), ga0, tbl[k].a);
                            chk_w($sformatf("probe%0d_g_b", n), gb0, tbl[k].b);
                            chk_w($sformatf("probe%0d_g_c", n), gc0, tbl[k].c);
                            chk_w($sformatf("probe%0d_g_d", n), gd0, tbl[k].d);
                        end
                        chk_w($sformatf("probe%0d_g_m0", n), gm00, tbl[k].m0);
                        chk_w($sformatf("probe%0d_g_m1", n), gm10, tbl[k].m1);
                    end
                end
            end
            if (done0) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    vfinal  = v_out0;
                end
            end
            if (ready0 && done_at >= 0 && ready_at < 0) ready_at = n;
            start0 = busy && (n == 19 || n == 95 || n == 96);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk_i({tag, "_done_cycle"}, done_at, 96);
        chk_i({tag, "_done_count"}, done_cnt, 1);
        chk_i({tag, "_ready_back"}, ready_at, 97);
        chk_w({tag, "_v_out_hold"}, v_out0, vfinal);
        $display("run %s: done seen %0d cycles after start edge", tag, done_at);
    endtask

    task automatic check_digest(input string tag, input logic [1023:0] vf, input logic [1023:0] vin);
        logic [511:0] digest;
        logic [63:0]  w, got;
        digest = 512'hBA80A53F981C4D0D6A2797B69F12F6E94C212F14685AC4B74B12BB6FDBFFA2D17D87C5392AAB792DC252D5DE4533CC9518D38AA8DBF1925AB92386EDD4009923;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = digest[511 - 8*(8*k + i) -: 8];
            got = vf[64*k +: 64] ^ vf[64*(k+8) +: 64] ^ vin[64*k +: 64];
            chk_w($sformatf("%s_h%0d", tag, k), got, w);
        end
    endtask

    task automatic run_dut1(input string tag, input logic [1023:0] vin, input logic [1023:0] min,
                            input logic [1023:0] exp);
        int done_at;
        done_at = -1;
        @(negedge clk);
        v_in1 = vin; m_in1 = min; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n <= 20 && done_at < 0; n++) begin
            if (done1) done_at = n;
            else @(negedge clk);
        end
        chk_i({tag, "_done_cycle"}, done_at, 8);
        chk_w({tag, "_v_out"}, v_out1, exp);
        @(negedge clk);
        chk_i({tag, "_ready_back"}, int'(ready1), 1);
        $display("run %s: done seen %0d cycles after start edge", tag, done_at);
    endtask

    initial begin
        logic [1023:0] seq_v, seq_m, abc_v, abc_m, vfinal, vfinal2, zero;
        logic [255:0]  r0, r1, r2, r3;
        logic [63:0]   mv [16];
        int            idx [8][4];
        int            done_seen;

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        v_in0 = '0; m_in0 = '0; v_in1 = '0; m_in1 = '0; zero = '0;

        for (int i = 0; i < 16; i++) begin
            seq_v[64*i +: 64] = 64'(i);
            seq_m[64*i +: 64] = 64'h100 + 64'(i);
        end
        abc_m = '0;
        abc_m[63:0] = 64'h0000000000636261;
        for (int i = 0; i < 8; i++) begin
            abc_v[64*i +: 64]     = IV[i] ^ ((i == 0) ? 64'h01010040 : 64'h0);
            abc_v[64*(i+8) +: 64] = IV[i];
        end
        abc_v[64*12 +: 64] = abc_v[64*12 +: 64] ^ 64'd3;
        abc_v[64*14 +: 64] = ~abc_v[64*14 +: 64];

        // Round 0 columns feeding the first diagonal G5 (1,6,11,12).
        r0 = g_fn(64'd0, 64'd4, 64'd8,  64'd12, 64'h100, 64'h101);
        r1 = g_fn(64'd1, 64'd5, 64'd9,  64'd13, 64'h102, 64'h103);
        r2 = g_fn(64'd2, 64'd6, 64'd10, 64'd14, 64'h104, 64'h105);
        r3 = g_fn(64'd3, 64'd7, 64'd11, 64'd15, 64'h106, 64'h107);

        tbl[0] = '{0,  1'b1, 64'd0, 64'd4, 64'd8,  64'd12, 64'h100, 64'h101};
        tbl[1] = '{1,  1'b1, 64'd1, 64'd5, 64'd9,  64'd13, 64'h102, 64'h103};
        tbl[2] = '{3,  1'b1, 64'd3, 64'd7, 64'd11, 64'd15, 64'h106, 64'h107};
        tbl[3] = '{5,  1'b1, r1[255:192], r2[191:128], r3[127:64], r0[63:0], 64'h10A, 64'h10B};
        tbl[4] = '{8,  1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h10E, 64'h10A};
        tbl[5] = '{9,  1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h104, 64'h108};
        tbl[6] = '{16, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h10B, 64'h108};
        tbl[7] = '{80, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h100, 64'h101};
        tbl[8] = '{88, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h10E, 64'h10A};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_i("reset_ready", int'(ready0), 1);
        chk_i("reset_done", int'(done0), 0);
        chk_w("reset_v_out", v_out0, zero);
        chk_i("reset_ready_r1", int'(ready1), 1);
        chk_w("reset_v_out_r1", v_out1, zero);

        run_dut0("sched", seq_v, seq_m, 1'b1, 1'b0, vfinal);

        run_dut0("abc", abc_v, abc_m, 1'b0, 1'b0, vfinal);
        check_digest("abc", vfinal, abc_v);

        run_dut0("abc_busy", abc_v, abc_m, 1'b0, 1'b1, vfinal2);
        chk_w("abc_busy_same_v", vfinal2, vfinal);

        // Reset asserted in the middle of a compression.
        @(negedge clk);
        v_in0 = abc_v; m_in0 = abc_m; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (39) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_i("midrst_ready", int'(ready0), 1);
        chk_i("midrst_done", int'(done0), 0);
        chk_w("midrst_v_out", v_out0, zero);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 110; n++) begin
            if (done0) done_seen++;
            @(negedge clk);
        end
        chk_i("midrst_no_done", done_seen, 0);
        $display("run midrst: aborted at cycle 40");
        run_dut0("abc_after_rst", abc_v, abc_m, 1'b0, 1'b0, vfinal2);
        check_digest("abc_after_rst", vfinal2, abc_v);

        // ROUNDS=1 instance: eight G calls, message row 0 is the identity.
        idx = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        run_dut1("r1_zero", zero, zero, zero);
        for (int i = 0; i < 16; i++) mv[i] = 64'(i);
        for (int c = 0; c < 8; c++) begin
            r0 = g_fn(mv[idx[c][0]], mv[idx[c][1]], mv[idx[c][2]], mv[idx[c][3]],
                      64'h100 + 64'(2*c), 64'h101 + 64'(2*c));
            mv[idx[c][0]] = r0[255:192];
            mv[idx[c][1]] = r0[191:128];
            mv[idx[c][2]] = r0[127:64];
            mv[idx[c][3]] = r0[63:0];
        end
        for (int i = 0; i < 16; i++) vfinal[64*i +: 64] = mv[i];
        run_dut1("r1_seq", seq_v, seq_m, vfinal);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
